// File: rtl/fir_2mult_pkg.sv
// Shared types and constants for the two-multiplier FIR sample sequencer.
package fir_2mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_e;

  function automatic int unsigned pairs_per_output(input int unsigned num_taps);
    return num_taps / 2;
  endfunction

endpackage

// File: rtl/fir_2mult_seq_if.sv
// Sample handshake, samples-RAM port and MAC strobe bundle for the FIR sequencer.
interface fir_2mult_seq_if #(
  parameter int unsigned DataWidth = 18,
  parameter int unsigned AddrWidth = 7
);
  logic                 sample_valid_i;
  logic                 sample_ready_o;
  logic [DataWidth-1:0] sample_i;
  logic                 clear_i;
  logic                 busy_o;
  logic                 ram_wen_o;
  logic [AddrWidth-1:0] ram_wr_addr_o;
  logic [DataWidth-1:0] ram_data_o;
  logic                 ram_ren_o;
  logic [AddrWidth-1:0] ram_rd_addr1_o;
  logic [AddrWidth-1:0] ram_rd_addr2_o;
  logic [AddrWidth-1:0] coef_idx1_o;
  logic [AddrWidth-1:0] coef_idx2_o;
  logic                 mac_en_o;
  logic                 mac_clr_o;
  logic                 mac_last_o;

  modport master (
    output sample_valid_i, sample_i, clear_i,
    input  sample_ready_o, busy_o, ram_wen_o, ram_wr_addr_o, ram_data_o, ram_ren_o,
           ram_rd_addr1_o, ram_rd_addr2_o, coef_idx1_o, coef_idx2_o,
           mac_en_o, mac_clr_o, mac_last_o
  );

  modport slave (
    input  sample_valid_i, sample_i, clear_i,
    output sample_ready_o, busy_o, ram_wen_o, ram_wr_addr_o, ram_data_o, ram_ren_o,
           ram_rd_addr1_o, ram_rd_addr2_o, coef_idx1_o, coef_idx2_o,
           mac_en_o, mac_clr_o, mac_last_o
  );
endinterface

// File: rtl/fir_2mult_seq.sv
// Circular delay-line sequencer: writes one sample, then issues NumTaps/2 dual reads
// with coefficient indices and MAC strobes aligned to the RAM's one-cycle read latency.
module fir_2mult_seq
  import fir_2mult_pkg::*;
#(
  parameter int unsigned DataWidth = 18,
  parameter int unsigned AddrWidth = 7,
  parameter int unsigned NumTaps   = 128
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  fir_2mult_seq_if.slave bus
);

  localparam int unsigned Pairs  = pairs_per_output(NumTaps);
  localparam int unsigned JWidth = (Pairs > 1) ? $clog2(Pairs) : 1;
  localparam logic [JWidth-1:0]    JLast = JWidth'(Pairs - 1);
  localparam logic [AddrWidth-1:0] KLast = '1;

  if ((NumTaps % 2) != 0 || NumTaps < 2 || NumTaps > (1 << AddrWidth)) begin : g_bad_cfg
    $error("fir_2mult_seq: NumTaps must be even and within 2..2**AddrWidth");
  end

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0] base_q, base_d;
  logic [AddrWidth-1:0] k_q, k_d;
  logic [JWidth-1:0]    j_q, j_d;
  logic                 mac_en_q, mac_clr_q, mac_last_q;

  logic                 ready, wen, ren, first_pair, last_pair;
  logic [AddrWidth-1:0] waddr, rd_addr1, rd_addr2, coef1, coef2, two_j;
  logic [DataWidth-1:0] wdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      base_q     <= '0;
      k_q        <= '0;
      j_q        <= '0;
      mac_en_q   <= 1'b0;
      mac_clr_q  <= 1'b0;
      mac_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      base_q     <= base_d;
      k_q        <= k_d;
      j_q        <= j_d;
      mac_en_q   <= ren;
      mac_clr_q  <= first_pair;
      mac_last_q <= last_pair;
    end
  end

  // Next state and the combinational RAM-side controls.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    base_d     = base_q;
    k_d        = k_q;
    j_d        = j_q;
    ready      = 1'b0;
    wen        = 1'b0;
    waddr      = '0;
    wdata      = '0;
    ren        = 1'b0;
    rd_addr1   = '0;
    rd_addr2   = '0;
    coef1      = '0;
    coef2      = '0;
    first_pair = 1'b0;
    last_pair  = 1'b0;
    two_j      = AddrWidth'({j_q, 1'b0});

    unique case (state_q)
      IDLE: begin
        if (bus.clear_i) begin
          state_d = CLEAR;
        end else begin
          ready = 1'b1;
          if (bus.sample_valid_i) begin
            wen      = 1'b1;
            waddr    = wr_ptr_q;
            wdata    = bus.sample_i;
            base_d   = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + AddrWidth'(1);
            j_d      = '0;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        ren        = 1'b1;
        rd_addr1   = base_q - two_j;
        rd_addr2   = base_q - two_j - AddrWidth'(1);
        coef1      = two_j;
        coef2      = two_j + AddrWidth'(1);
        first_pair = (j_q == '0);
        last_pair  = (j_q == JLast);
        if (last_pair) begin
          j_d     = '0;
          state_d = IDLE;
        end else begin
          j_d = j_q + JWidth'(1);
        end
      end
      CLEAR: begin
        wen   = 1'b1;
        waddr = k_q;
        k_d   = k_q + AddrWidth'(1);
        if (k_q == KLast) begin
          wr_ptr_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sample_ready_o = ready;
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.ram_wen_o      = wen;
  assign bus.ram_wr_addr_o  = waddr;
  assign bus.ram_data_o     = wdata;
  assign bus.ram_ren_o      = ren;
  assign bus.ram_rd_addr1_o = rd_addr1;
  assign bus.ram_rd_addr2_o = rd_addr2;
  assign bus.coef_idx1_o    = coef1;
  assign bus.coef_idx2_o    = coef2;
  assign bus.mac_en_o       = mac_en_q;
  assign bus.mac_clr_o      = mac_clr_q;
  assign bus.mac_last_o     = mac_last_q;

endmodule
